ps2_msx_matrix: RTL and testbench
=================================

Name: ps2_msx_matrix

Overview:
- Keyboard-side counterpart of the console's keyboard scan path.
- The PPI drives the row select (keyMAT, PC[3:0]) and reads column bits on port B (PB).
- This block receives a PS/2 set-2 keyboard stream, keeps an 11-row x 8-column MSX key matrix, and returns the selected row, active-low, on PB.
- It replaces the physical MSX keyboard matrix on the console board.

Parameters:
- FILTER_LEN, 4: cycles PS2_CLK must be stable after synchronisation before an edge is accepted.
- TIMEOUT_CYCLES, 3580: idle cycles (about 1 ms at 3.58 MHz) inside a frame before the receiver aborts.

Ports:
- CLK  input  1  system clock; all state on its rising edge.
- RSTb  input  1  reset, asynchronous, active-low.
- PS2_CLK  input  1  PS/2 clock from keyboard; asynchronous.
- PS2_DAT  input  1  PS/2 data from keyboard; asynchronous.
- keyMAT  input  4  matrix row select from PPI port C[3:0].
- PB  output  8  column bits of the selected row; 0 = pressed.
- KEY_EVENT  output  1  one-cycle pulse when a mapped key changes state in the matrix.
- RX_ERR  output  1  one-cycle pulse on a framing, parity or timeout error.
- SOFT_RSTb  output  1  reset request, active-low; present only with the optional feature.

Behaviour:
- Reset (RSTb low), asynchronous and also mid-frame:
  - Receiver returns to IDLE; prefix flags and skip counter clear.
  - Matrix clears to all released, so PB = FFh for every row.
  - KEY_EVENT = 0, RX_ERR = 0, SOFT_RSTb = 1.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass a 2-flop synchroniser.
  - The PS2_CLK filter updates its filtered level only after FILTER_LEN equal consecutive samples.
  - A falling edge of the filtered clock is a bit strobe; data is sampled from the synchronised PS2_DAT on the strobe cycle.
- Receiver FSM:
  - IDLE -> DATA when a strobe samples 0 (start bit); a strobe sampling 1 in IDLE is ignored.
  - DATA: 8 strobes, LSB first, into the shift register -> PARITY.
  - PARITY: 1 strobe; odd parity over data+parity is required -> STOP.
  - STOP: 1 strobe; stop bit must be 1. Then -> IDLE with the byte valid on the next cycle (N+1, where N is the stop strobe cycle).
  - Parity or stop failure: byte discarded, RX_ERR pulses at N+1, -> IDLE.
  - Timeout: a counter resets on every strobe. In any state other than IDLE, reaching TIMEOUT_CYCLES -> IDLE with an RX_ERR pulse. A strobe in the same cycle as expiry wins.
- Byte decoder, acting on a valid byte at N+1:
  - E0h sets ext; F0h sets brk. Both persist until the next non-prefix byte.
  - E1h loads a skip counter of 7; the next 7 bytes are dropped, so Pause has no effect.
  - 00h and FFh (overrun): whole matrix released, flags cleared, KEY_EVENT pulses once.
  - AAh, FAh, FEh, EEh: ignored; flags cleared.
  - Any other byte is looked up by {ext, code} in the combinational map.
    - Hit: matrix[row][col] <= ~brk at N+2. KEY_EVENT pulses at N+2 only if the bit changed.
    - Miss: no change.
    - Flags clear after the lookup in either case.
- Required map entries (others per the team key table):
  - 1Ch A -> row 2 bit 6
  - 12h LShift -> row 6 bit 0
  - 14h Ctrl -> row 6 bit 1
  - 76h Esc -> row 7 bit 2
  - 5Ah Enter -> row 7 bit 7
  - 29h Space -> row 8 bit 0
  - E0 75h Up -> row 8 bit 5
  - 58h CapsLock -> row 6 bit 3
- Readback:
  - PB = ~matrix[keyMAT] combinationally; keyMAT 11..15 -> FFh.
  - A matrix update is visible on PB at N+2.
  - Multiple keys pressed in the same row show as multiple 0 bits.

Optional Feature:
- Macro: KBD_RESET_COMBO_EN.
- Defined:
  - When Ctrl, Alt (11h) and Delete (E0 71h) are all held in internal pressed flags, SOFT_RSTb goes low for 16 cycles starting the cycle after the third press is decoded.
  - Re-arms only after all three are released.
  - Alt and Delete need not appear in the MSX matrix.
- Undefined: SOFT_RSTb port absent; Alt and Delete are plain map lookups.

Test Plan:
- Reset, then sweep keyMAT 0..15 -> PB = FFh for all rows; KEY_EVENT = 0, RX_ERR = 0.
- Send frame 1Ch, keyMAT = 2 -> PB = BFh at N+2 with one KEY_EVENT pulse; then F0h, 1Ch -> PB = FFh with a second pulse.
- Send E0h, 75h then 29h, keyMAT = 8 -> PB = DEh; then F0h, 29h -> PB = DFh.
- Send 5Ah with a bad parity bit -> RX_ERR pulse, row 7 stays FFh. Then stop PS2_CLK after 4 data bits for TIMEOUT_CYCLES -> RX_ERR pulse; the next good 76h gives row 7 = FBh.
- Press 12h and 14h, then send 00h -> row 6 returns from FCh to FFh, one KEY_EVENT. Send E1 14 77 E1 F0 14 F0 77 -> no matrix change.
- With KBD_RESET_COMBO_EN: press 14h, 11h, E0 71h -> SOFT_RSTb low for exactly 16 cycles. Repeat the Delete press without releasing all three -> no second pulse. Assert RSTb mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_msx_matrix.sv
// PS/2 set-2 keyboard receiver that maintains an 11x8 MSX key matrix and serves the PPI row read on PB.
// Optional build macro KBD_RESET_COMBO_EN adds a Ctrl+Alt+Delete soft-reset request on SOFT_RSTb.
module ps2_msx_matrix #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 3580
) (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [3:0] keyMAT,
  output logic [7:0] PB,
  output logic       KEY_EVENT,
  output logic       RX_ERR
`ifdef KBD_RESET_COMBO_EN
  ,
  output logic       SOFT_RSTb
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} rx_st_e;

  logic          c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic          flt_q, flt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe;
  rx_st_e        st_q, st_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d, byte_q, byte_d;
  logic          par_ok_q, par_ok_d, bvld_q, bvld_d, err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  logic          ext_q, ext_d, brk_q, brk_d, ev_q, ev_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0][7:0] mat_q, mat_d;
  logic [7:0]    km;
  logic          hit;
  logic [3:0]    hrow;
  logic [2:0]    hcol;
`ifdef KBD_RESET_COMBO_EN
  logic          ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d, armed_q, armed_d, srst_q, srst_d;
  logic [4:0]    rcnt_q, rcnt_d;
`endif

  function automatic logic [7:0] rc(input int r, input int c);
    rc = {1'b1, 4'(r), 3'(c)};
  endfunction

  // Lookup is keyed by {ext, code}; result is {hit, row, col}.
  function automatic logic [7:0] key_map(input logic [8:0] k);
    case (k)
      9'h045: key_map = rc(0, 0);  9'h016: key_map = rc(0, 1);
      9'h01E: key_map = rc(0, 2);  9'h026: key_map = rc(0, 3);
      9'h025: key_map = rc(0, 4);  9'h02E: key_map = rc(0, 5);
      9'h036: key_map = rc(0, 6);  9'h03D: key_map = rc(0, 7);
      9'h03E: key_map = rc(1, 0);  9'h046: key_map = rc(1, 1);
      9'h04E: key_map = rc(1, 2);  9'h055: key_map = rc(1, 3);
      9'h05D: key_map = rc(1, 4);  9'h054: key_map = rc(1, 5);
      9'h05B: key_map = rc(1, 6);  9'h04C: key_map = rc(1, 7);
      9'h052: key_map = rc(2, 0);  9'h00E: key_map = rc(2, 1);
      9'h041: key_map = rc(2, 2);  9'h049: key_map = rc(2, 3);
      9'h04A: key_map = rc(2, 4);  9'h01C: key_map = rc(2, 6);
      9'h032: key_map = rc(2, 7);  9'h021: key_map = rc(3, 0);
      9'h023: key_map = rc(3, 1);  9'h024: key_map = rc(3, 2);
      9'h02B: key_map = rc(3, 3);  9'h034: key_map = rc(3, 4);
      9'h033: key_map = rc(3, 5);  9'h043: key_map = rc(3, 6);
      9'h03B: key_map = rc(3, 7);  9'h042: key_map = rc(4, 0);
      9'h04B: key_map = rc(4, 1);  9'h03A: key_map = rc(4, 2);
      9'h031: key_map = rc(4, 3);  9'h044: key_map = rc(4, 4);
      9'h04D: key_map = rc(4, 5);  9'h015: key_map = rc(4, 6);
      9'h02D: key_map = rc(4, 7);  9'h01B: key_map = rc(5, 0);
      9'h02C: key_map = rc(5, 1);  9'h03C: key_map = rc(5, 2);
      9'h02A: key_map = rc(5, 3);  9'h01D: key_map = rc(5, 4);
      9'h022: key_map = rc(5, 5);  9'h035: key_map = rc(5, 6);
      9'h01A: key_map = rc(5, 7);  9'h012: key_map = rc(6, 0);
      9'h059: key_map = rc(6, 0);  9'h014: key_map = rc(6, 1);
      9'h114: key_map = rc(6, 1);  9'h011: key_map = rc(6, 2);
      9'h058: key_map = rc(6, 3);  9'h111: key_map = rc(6, 4);
      9'h005: key_map = rc(6, 5);  9'h006: key_map = rc(6, 6);
      9'h004: key_map = rc(6, 7);  9'h00C: key_map = rc(7, 0);
      9'h003: key_map = rc(7, 1);  9'h076: key_map = rc(7, 2);
      9'h00D: key_map = rc(7, 3);  9'h169: key_map = rc(7, 4);
      9'h066: key_map = rc(7, 5);  9'h17D: key_map = rc(7, 6);
      9'h05A: key_map = rc(7, 7);  9'h15A: key_map = rc(7, 7);
      9'h029: key_map = rc(8, 0);  9'h16C: key_map = rc(8, 1);
      9'h170: key_map = rc(8, 2);  9'h171: key_map = rc(8, 3);
      9'h16B: key_map = rc(8, 4);  9'h175: key_map = rc(8, 5);
      9'h172: key_map = rc(8, 6);  9'h174: key_map = rc(8, 7);
      default: key_map = 8'h00;
    endcase
  endfunction

  // A strobe is the cycle the filtered clock commits a high-to-low change.
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    strobe = 1'b0;
    if (c_s2_q != flt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        flt_d  = c_s2_q;
        strobe = flt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    par_ok_d = par_ok_q;
    byte_d   = byte_q;
    bvld_d   = 1'b0;
    err_d    = 1'b0;
    if (strobe) to_d = '0;
    else if (st_q != S_IDLE) to_d = to_q + 1'b1;
    else to_d = '0;
    case (st_q)
      S_IDLE: if (strobe && !d_s2_q) begin
        st_d   = S_DATA;
        bcnt_d = '0;
      end
      S_DATA: if (strobe) begin
        sh_d = {d_s2_q, sh_q[7:1]};
        if (bcnt_q == 3'd7) st_d = S_PAR;
        else bcnt_d = bcnt_q + 1'b1;
      end
      S_PAR: if (strobe) begin
        par_ok_d = ^{sh_q, d_s2_q};
        st_d     = S_STOP;
      end
      S_STOP: if (strobe) begin
        st_d = S_IDLE;
        if (d_s2_q && par_ok_q) begin
          bvld_d = 1'b1;
          byte_d = sh_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    // A strobe on the expiry cycle keeps the frame alive.
    if (!strobe && st_q != S_IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      st_d  = S_IDLE;
      err_d = 1'b1;
      to_d  = '0;
    end
  end

  assign km   = key_map({ext_q, byte_q});
  assign hit  = km[7];
  assign hrow = km[6:3];
  assign hcol = km[2:0];

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    mat_d  = mat_q;
    ev_d   = 1'b0;
`ifdef KBD_RESET_COMBO_EN
    ctrl_d = ctrl_q;
    alt_d  = alt_q;
    del_d  = del_q;
`endif
    if (bvld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        case (byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          8'h00, 8'hFF: begin
            mat_d = '0;
            ext_d = 1'b0;
            brk_d = 1'b0;
            ev_d  = 1'b1;
`ifdef KBD_RESET_COMBO_EN
            ctrl_d = 1'b0;
            alt_d  = 1'b0;
            del_d  = 1'b0;
`endif
          end
          8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (hit && (mat_q[hrow][hcol] == brk_q)) begin
              mat_d[hrow][hcol] = ~brk_q;
              ev_d = 1'b1;
            end
`ifdef KBD_RESET_COMBO_EN
            case ({ext_q, byte_q})
              9'h014:  ctrl_d = ~brk_q;
              9'h011:  alt_d  = ~brk_q;
              9'h171:  del_d  = ~brk_q;
              default: ;
            endcase
`endif
          end
        endcase
      end
    end
  end

`ifdef KBD_RESET_COMBO_EN
  always_comb begin
    armed_d = armed_q;
    rcnt_d  = (rcnt_q != 5'd0) ? rcnt_q - 1'b1 : 5'd0;
    if (!ctrl_q && !alt_q && !del_q) armed_d = 1'b1;
    if (armed_q && ctrl_d && alt_d && del_d) begin
      armed_d = 1'b0;
      rcnt_d  = 5'd16;
    end
    srst_d = (rcnt_d == 5'd0);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
      del_q   <= 1'b0;
      armed_q <= 1'b1;
      srst_q  <= 1'b1;
      rcnt_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
      del_q   <= del_d;
      armed_q <= armed_d;
      srst_q  <= srst_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign SOFT_RSTb = srst_q;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      c_s1_q <= 1'b1; c_s2_q <= 1'b1; d_s1_q <= 1'b1; d_s2_q <= 1'b1;
      flt_q  <= 1'b1; fcnt_q <= '0;
      st_q   <= S_IDLE; bcnt_q <= '0; sh_q <= '0; par_ok_q <= 1'b0;
      byte_q <= '0; bvld_q <= 1'b0; err_q <= 1'b0; to_q <= '0;
      ext_q  <= 1'b0; brk_q <= 1'b0; skip_q <= '0; mat_q <= '0; ev_q <= 1'b0;
    end else begin
      c_s1_q <= PS2_CLK; c_s2_q <= c_s1_q; d_s1_q <= PS2_DAT; d_s2_q <= d_s1_q;
      flt_q  <= flt_d; fcnt_q <= fcnt_d;
      st_q   <= st_d; bcnt_q <= bcnt_d; sh_q <= sh_d; par_ok_q <= par_ok_d;
      byte_q <= byte_d; bvld_q <= bvld_d; err_q <= err_d; to_q <= to_d;
      ext_q  <= ext_d; brk_q <= brk_d; skip_q <= skip_d; mat_q <= mat_d; ev_q <= ev_d;
    end
  end

  always_comb begin
    PB = 8'hFF;
    if (keyMAT <= 4'd10) PB = ~mat_q[keyMAT];
  end

  assign KEY_EVENT = ev_q;
  assign RX_ERR    = err_q;

endmodule

// File: tb/tb_ps2_msx_matrix.sv
// Directed bench for ps2_msx_matrix: PS/2 frames in, PB rows and event/error pulse counts checked.
module tb_ps2_msx_matrix;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [3:0] keyMAT = 4'd0;
  logic [7:0] PB;
  logic       KEY_EVENT, RX_ERR;
`ifdef KBD_RESET_COMBO_EN
  logic       SOFT_RSTb;
  int         lo_n = 0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int ev_n = 0;
  int er_n = 0;
  logic [7:0] v;
  int e0;

  ps2_msx_matrix dut (
    .CLK(CLK), .RSTb(RSTb), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .keyMAT(keyMAT), .PB(PB), .KEY_EVENT(KEY_EVENT), .RX_ERR(RX_ERR)
`ifdef KBD_RESET_COMBO_EN
    , .SOFT_RSTb(SOFT_RSTb)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (KEY_EVENT === 1'b1) ev_n++;
    if (RX_ERR === 1'b1) er_n++;
`ifdef KBD_RESET_COMBO_EN
    if (SOFT_RSTb === 1'b0) lo_n++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] r, output logic [7:0] val);
    keyMAT = r;
    @(negedge CLK);
    val = PB;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (10) @(posedge CLK);
    PS2_CLK = 1'b0;
    repeat (10) @(posedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (20) @(posedge CLK);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    for (int r = 0; r < 16; r++) begin
      rd(4'(r), v);
      chk($sformatf("rst_row%0d", r), {24'd0, v}, 32'hFF);
    end
    chk("rst_event", {31'd0, KEY_EVENT}, 32'd0);
    chk("rst_rxerr", {31'd0, RX_ERR}, 32'd0);
`ifdef KBD_RESET_COMBO_EN
    chk("rst_softrst", {31'd0, SOFT_RSTb}, 32'd1);
`endif
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (5) @(posedge CLK);

    // A press and release
    send(8'h1C, 1'b0);
    rd(4'd2, v); chk("a_press", {24'd0, v}, 32'hBF);
    chk("a_press_ev", ev_n, 32'd1);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    rd(4'd2, v); chk("a_rel", {24'd0, v}, 32'hFF);
    chk("a_rel_ev", ev_n, 32'd2);

    // Extended Up plus Space share row 8
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'h29, 1'b0);
    rd(4'd8, v); chk("up_space", {24'd0, v}, 32'hDE);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    rd(4'd8, v); chk("up_only", {24'd0, v}, 32'hDF);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    rd(4'd8, v); chk("up_rel", {24'd0, v}, 32'hFF);

    // Parity error, then timeout, then a good Esc
    send(8'h5A, 1'b1);
    chk("par_err", er_n, 32'd1);
    rd(4'd7, v); chk("par_row7", {24'd0, v}, 32'hFF);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (4000) @(posedge CLK);
    chk("timeout_err", er_n, 32'd2);
    send(8'h76, 1'b0);
    rd(4'd7, v); chk("esc_press", {24'd0, v}, 32'hFB);
    chk("esc_noerr", er_n, 32'd2);
    send(8'hF0, 1'b0); send(8'h76, 1'b0);

    // Shift+Ctrl, then overrun clears everything
    send(8'h12, 1'b0); send(8'h14, 1'b0);
    rd(4'd6, v); chk("shift_ctrl", {24'd0, v}, 32'hFC);
    e0 = ev_n;
    send(8'h00, 1'b0);
    rd(4'd6, v); chk("overrun_row6", {24'd0, v}, 32'hFF);
    chk("overrun_ev", ev_n - e0, 32'd1);

    // Pause sequence must be swallowed
    e0 = ev_n;
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
    rd(4'd6, v); chk("pause_row6", {24'd0, v}, 32'hFF);
    chk("pause_ev", ev_n - e0, 32'd0);
    send(8'h29, 1'b0);
    rd(4'd8, v); chk("after_pause", {24'd0, v}, 32'hFE);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);

`ifdef KBD_RESET_COMBO_EN
    send(8'h14, 1'b0); send(8'h11, 1'b0);
    chk("combo_none_yet", lo_n, 32'd0);
    send(8'hE0, 1'b0); send(8'h71, 1'b0);
    repeat (40) @(posedge CLK);
    chk("combo_pulse", lo_n, 32'd16);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h71, 1'b0);
    send(8'hE0, 1'b0); send(8'h71, 1'b0);
    repeat (40) @(posedge CLK);
    chk("combo_no_rearm", lo_n, 32'd16);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h11, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h71, 1'b0);
`endif

    // Reset in the middle of a frame
    send(8'h1C, 1'b0);
    rd(4'd2, v); chk("pre_rst_a", {24'd0, v}, 32'hBF);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    RSTb = 1'b0;
    #3;
    chk("midrst_row2", {24'd0, PB}, 32'hFF);
    chk("midrst_event", {31'd0, KEY_EVENT}, 32'd0);
    chk("midrst_rxerr", {31'd0, RX_ERR}, 32'd0);
`ifdef KBD_RESET_COMBO_EN
    chk("midrst_softrst", {31'd0, SOFT_RSTb}, 32'd1);
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (5) @(posedge CLK);
    e0 = er_n;
    send(8'h29, 1'b0);
    rd(4'd8, v); chk("post_rst_space", {24'd0, v}, 32'hFE);
    rd(4'd2, v); chk("post_rst_row2", {24'd0, v}, 32'hFF);
    chk("post_rst_noerr", er_n - e0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
